// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, shifter kinds,
// forwarding selects, the status register layout and a rotate helper.
package exe_stage_pkg;

    // ALU operation encodings carried in exe_cmd
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    // Register-operand shifter kinds, shift_operand[6:5]
    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    // Forwarding selects; 2'b11 falls back to the register value
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Status register, packed as {N,Z,C,V}
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } sr_t;

    // Rotate right by 0..31; a zero amount returns the input unchanged
    // because the left shift by 32 contributes nothing.
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
        ror32 = (x >> amt) | (x << (6'd32 - {1'b0, amt}));
    endfunction

endpackage

// File: rtl/exe_stage_val2_gen.sv
// Second-operand generator: memory offset, rotated immediate or shifted Rm.
module exe_stage_val2_gen
    import exe_stage_pkg::*;
(
    input  logic        mem_en,
    input  logic        imm,
    input  logic [11:0] shift_operand,
    input  logic [31:0] rm_f,
    output logic [31:0] val2
);

    logic [4:0] shamt_s;
    logic [4:0] imm_rot_s;

    assign shamt_s   = shift_operand[11:7];
    assign imm_rot_s = {shift_operand[11:8], 1'b0};

    // Pick the operand source by priority: memory offset, immediate, shifter
    always_comb begin
        val2 = 32'd0;
        if (mem_en) begin
            val2 = {20'd0, shift_operand};
        end else if (imm) begin
            val2 = ror32({24'd0, shift_operand[7:0]}, imm_rot_s);
        end else begin
            case (shift_operand[6:5])
                SHIFT_LSL: val2 = rm_f << shamt_s;
                SHIFT_LSR: val2 = rm_f >> shamt_s;
                SHIFT_ASR: val2 = $signed(rm_f) >>> shamt_s;
                SHIFT_ROR: val2 = ror32(rm_f, shamt_s);
                default:   val2 = rm_f;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, branch target, NZCV status
// register and the EXE/MEM pipeline register.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int         DW     = 32,
    parameter logic [3:0] SR_RST = 4'b0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          freeze,
    input  logic          wb_en,
    input  logic          mem_r_en,
    input  logic          mem_w_en,
    input  logic          b,
    input  logic          s,
    input  logic          imm,
    input  logic [3:0]    exe_cmd,
    input  logic [3:0]    dest,
    input  logic [11:0]   shift_operand,
    input  logic [23:0]   signed_imm_24,
    input  logic [DW-1:0] pc,
    input  logic [DW-1:0] val_rn,
    input  logic [DW-1:0] val_rm,
    input  logic [1:0]    sel_src1,
    input  logic [1:0]    sel_src2,
    input  logic [DW-1:0] mem_fwd_val,
    input  logic [DW-1:0] wb_fwd_val,
    output logic [3:0]    sr,
    output logic          branch_taken,
    output logic [DW-1:0] branch_addr,
    output logic          wb_en_o,
    output logic          mem_r_en_o,
    output logic          mem_w_en_o,
    output logic [DW-1:0] alu_res_o,
    output logic [DW-1:0] val_rm_o,
    output logic [3:0]    dest_o
);

    logic [DW-1:0] op1_s;
    logic [DW-1:0] rm_f_s;
    logic [DW-1:0] val2_s;
    logic [DW-1:0] add_b_s;
    logic          cin_s;
    logic          op_valid_s;
    logic          op_arith_s;
    logic [DW-1:0] logic_res_s;
    logic [DW:0]   sum_s;
    logic [DW-1:0] alu_res_s;
    sr_t           flags_s;
    logic          mem_en_s;
    logic          sr_we_s;

    sr_t           sr_r;
    logic          wb_en_r;
    logic          mem_r_en_r;
    logic          mem_w_en_r;
    logic [DW-1:0] alu_res_r;
    logic [DW-1:0] val_rm_r;
    logic [3:0]    dest_r;

    assign mem_en_s = mem_r_en | mem_w_en;
    // Memory ops use the ALU only for address generation, never for flags
    assign sr_we_s  = s & ~mem_en_s;

    // Forwarding muxes for Rn and Rm
    always_comb begin
        case (sel_src1)
            FWD_MEM: op1_s = mem_fwd_val;
            FWD_WB:  op1_s = wb_fwd_val;
            default: op1_s = val_rn;
        endcase
        case (sel_src2)
            FWD_MEM: rm_f_s = mem_fwd_val;
            FWD_WB:  rm_f_s = wb_fwd_val;
            default: rm_f_s = val_rm;
        endcase
    end

    exe_stage_val2_gen u_val2_gen (
        .mem_en        (mem_en_s),
        .imm           (imm),
        .shift_operand (shift_operand),
        .rm_f          (rm_f_s),
        .val2          (val2_s)
    );

    // Decode the ALU op into adder controls or a logical result
    always_comb begin
        add_b_s     = val2_s;
        cin_s       = 1'b0;
        op_valid_s  = 1'b1;
        op_arith_s  = 1'b0;
        logic_res_s = {DW{1'b0}};
        case (exe_cmd)
            EXE_MOV: logic_res_s = val2_s;
            EXE_MVN: logic_res_s = ~val2_s;
            EXE_AND: logic_res_s = op1_s & val2_s;
            EXE_ORR: logic_res_s = op1_s | val2_s;
            EXE_EOR: logic_res_s = op1_s ^ val2_s;
            EXE_ADD: op_arith_s = 1'b1;
            EXE_ADC: begin
                op_arith_s = 1'b1;
                cin_s      = sr_r.c;
            end
            EXE_SUB: begin
                op_arith_s = 1'b1;
                add_b_s    = ~val2_s;
                cin_s      = 1'b1;
            end
            EXE_SBC: begin
                op_arith_s = 1'b1;
                add_b_s    = ~val2_s;
                cin_s      = sr_r.c;
            end
            default: op_valid_s = 1'b0;
        endcase
    end

    assign sum_s = {1'b0, op1_s} + {1'b0, add_b_s} + {{DW{1'b0}}, cin_s};

    // Select the ALU result and derive the next NZCV value
    always_comb begin
        flags_s = sr_r;
        if (op_arith_s) begin
            alu_res_s = sum_s[DW-1:0];
            flags_s.c = sum_s[DW];
            flags_s.v = (op1_s[DW-1] == add_b_s[DW-1]) && (sum_s[DW-1] != op1_s[DW-1]);
        end else begin
            alu_res_s = logic_res_s;
        end
        if (op_valid_s) begin
            flags_s.n = alu_res_s[DW-1];
            flags_s.z = (alu_res_s == {DW{1'b0}});
        end else begin
            flags_s.n = sr_r.n;
            flags_s.z = sr_r.z;
        end
    end

    // Status register: async reset, held under freeze, written only when s applies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r <= sr_t'(SR_RST);
        end else if (!freeze && sr_we_s) begin
            sr_r <= flags_s;
        end
    end

    // EXE/MEM pipeline register, held while MEM stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_r    <= 1'b0;
            mem_r_en_r <= 1'b0;
            mem_w_en_r <= 1'b0;
            alu_res_r  <= {DW{1'b0}};
            val_rm_r   <= {DW{1'b0}};
            dest_r     <= 4'd0;
        end else if (!freeze) begin
            wb_en_r    <= wb_en;
            mem_r_en_r <= mem_r_en;
            mem_w_en_r <= mem_w_en;
            alu_res_r  <= alu_res_s;
            val_rm_r   <= rm_f_s;
            dest_r     <= dest;
        end
    end

    assign sr           = sr_r;
    assign wb_en_o      = wb_en_r;
    assign mem_r_en_o   = mem_r_en_r;
    assign mem_w_en_o   = mem_w_en_r;
    assign alu_res_o    = alu_res_r;
    assign val_rm_o     = val_rm_r;
    assign dest_o       = dest_r;

    // Branch target: word offset sign-extended and scaled, wrapping mod 2^32
    assign branch_taken = b;
    assign branch_addr  = pc + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};

endmodule
